// File: rtl/frame_swap_controller_if.sv
// Drawing-side bus between the DrawingManager and the frame swap controller.
//   draw_write_en/addr/data : pixel write from the drawer
//   frame_done              : level, drawer has finished the current frame
//   draw_start / draw_ack   : one-cycle pulses back to the drawer
// master = DrawingManager side, slave = controller side.
interface frame_swap_controller_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12
);
  logic              draw_write_en;
  logic [ADDR_W-1:0] draw_write_addr;
  logic [DATA_W-1:0] draw_write_data;
  logic              frame_done;
  logic              draw_start;
  logic              draw_ack;

  modport master (
    output draw_write_en, draw_write_addr, draw_write_data, frame_done,
    input  draw_start, draw_ack
  );

  modport slave (
    input  draw_write_en, draw_write_addr, draw_write_data, frame_done,
    output draw_start, draw_ack
  );
endinterface

// File: rtl/frame_swap_controller.sv
// Double-buffer controller between the DrawingManager and two frame buffer RAMs.
// Pixel writes are registered once and steered to the back buffer; the buffers
// swap on a display vsync only after the drawer reports frame_done, so the
// scanned-out frame never tears.
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   vsync            one-cycle display frame boundary pulse (clk domain)
//   draw             drawing-side bus (writes, frame_done, draw_start, draw_ack)
//   buffer_select    back buffer index (being drawn)
//   display_select   front buffer index (being scanned), always ~buffer_select
//   fb0_*/fb1_*      write ports of buffer 0 / buffer 1
// Optional: define FRAME_SWAP_STATS_EN to add the saturating counters
//   frames_presented, vsyncs_missed and writes_dropped.
module frame_swap_controller #(
  parameter int BUFFER_WIDTH      = 160,
  parameter int BUFFER_HEIGHT     = 120,
  parameter int BUFFER_DATA_WIDTH = 12,
  parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH*BUFFER_HEIGHT),
  parameter int VSYNC_DIVIDE      = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         vsync,
  frame_swap_controller_if.slave       draw,
  output logic                         buffer_select,
  output logic                         display_select,
  output logic                         fb0_write_en,
  output logic [BUFFER_ADDR_WIDTH-1:0] fb0_write_addr,
  output logic [BUFFER_DATA_WIDTH-1:0] fb0_write_data,
  output logic                         fb1_write_en,
  output logic [BUFFER_ADDR_WIDTH-1:0] fb1_write_addr,
  output logic [BUFFER_DATA_WIDTH-1:0] fb1_write_data
`ifdef FRAME_SWAP_STATS_EN
  ,
  output logic [15:0]                  frames_presented,
  output logic [15:0]                  vsyncs_missed,
  output logic [15:0]                  writes_dropped
`endif
);

  localparam logic [4:0] DIV = 5'(VSYNC_DIVIDE);

  typedef enum logic [1:0] {S_START, S_DRAWING, S_WAIT_VSYNC, S_SWAP} state_t;

  state_t     state, state_nx;
  logic [3:0] vsync_count;
  logic       div_hit;
  logic       wr_ok;

  // Widened by one bit so a saturated count of 15 plus one still compares.
  assign div_hit = ({1'b0, vsync_count} + 5'd1) >= DIV;

  // Writes only land while the drawer owns a stable back buffer.
  assign wr_ok = draw.draw_write_en && (state == S_DRAWING || state == S_WAIT_VSYNC);

  assign display_select = ~buffer_select;

  always_ff @(posedge clk) begin
    if (!rstn) state <= S_START;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_START:      state_nx = S_DRAWING;
      S_DRAWING:    if (draw.frame_done) state_nx = S_WAIT_VSYNC;
      S_WAIT_VSYNC: if (vsync && div_hit) state_nx = S_SWAP;
      S_SWAP:       state_nx = S_DRAWING;
      default:      state_nx = S_START;
    endcase
  end

  // Handshake pulses, buffer select and vsync counter. The swap is committed
  // on the edge entering SWAP so draw_ack and the new select appear together.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      draw.draw_start <= 1'b0;
      draw.draw_ack   <= 1'b0;
      buffer_select   <= 1'b0;
      vsync_count     <= '0;
    end else begin
      draw.draw_start <= (state == S_START);
      draw.draw_ack   <= (state_nx == S_SWAP);
      if (state_nx == S_SWAP) begin
        buffer_select <= ~buffer_select;
        vsync_count   <= '0;
      end else if (vsync && vsync_count != 4'hF) begin
        vsync_count   <= vsync_count + 4'd1;
      end
    end
  end

  // Single write register stage, steered by the back buffer index at issue time.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fb0_write_en   <= 1'b0;
      fb0_write_addr <= '0;
      fb0_write_data <= '0;
      fb1_write_en   <= 1'b0;
      fb1_write_addr <= '0;
      fb1_write_data <= '0;
    end else begin
      fb0_write_en <= wr_ok && !buffer_select;
      fb1_write_en <= wr_ok &&  buffer_select;
      if (wr_ok && !buffer_select) begin
        fb0_write_addr <= draw.draw_write_addr;
        fb0_write_data <= draw.draw_write_data;
      end
      if (wr_ok && buffer_select) begin
        fb1_write_addr <= draw.draw_write_addr;
        fb1_write_data <= draw.draw_write_data;
      end
    end
  end

`ifdef FRAME_SWAP_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      frames_presented <= '0;
      vsyncs_missed    <= '0;
      writes_dropped   <= '0;
    end else begin
      if (state == S_SWAP && frames_presented != 16'hFFFF)
        frames_presented <= frames_presented + 16'd1;
      if (vsync && state == S_DRAWING && vsyncs_missed != 16'hFFFF)
        vsyncs_missed <= vsyncs_missed + 16'd1;
      if (draw.draw_write_en && (state == S_START || state == S_SWAP) &&
          writes_dropped != 16'hFFFF)
        writes_dropped <= writes_dropped + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_swap_controller.sv
module tb_frame_swap_controller;
  localparam int AW = 15;
  localparam int DW = 12;

  logic clk = 1'b0;
  logic rstn;
  logic vsync_a, vsync_b;
  int   vec  = 0;
  int   miss = 0;
  int   acks;

  always #5 clk = ~clk;

  frame_swap_controller_if #(.ADDR_W(AW), .DATA_W(DW)) a_if ();
  frame_swap_controller_if #(.ADDR_W(AW), .DATA_W(DW)) b_if ();

  logic          a_bsel, a_dsel, a_e0, a_e1;
  logic [AW-1:0] a_a0, a_a1;
  logic [DW-1:0] a_d0, a_d1;
  logic          b_bsel, b_dsel, b_e0, b_e1;
  logic [AW-1:0] b_a0, b_a1;
  logic [DW-1:0] b_d0, b_d1;
`ifdef FRAME_SWAP_STATS_EN
  logic [15:0] a_fp, a_vm, a_wd, b_fp, b_vm, b_wd;
`endif

  frame_swap_controller #(.VSYNC_DIVIDE(1)) dut_a (
    .clk(clk), .rstn(rstn), .vsync(vsync_a), .draw(a_if),
    .buffer_select(a_bsel), .display_select(a_dsel),
    .fb0_write_en(a_e0), .fb0_write_addr(a_a0), .fb0_write_data(a_d0),
    .fb1_write_en(a_e1), .fb1_write_addr(a_a1), .fb1_write_data(a_d1)
`ifdef FRAME_SWAP_STATS_EN
    , .frames_presented(a_fp), .vsyncs_missed(a_vm), .writes_dropped(a_wd)
`endif
  );

  frame_swap_controller #(.VSYNC_DIVIDE(3)) dut_b (
    .clk(clk), .rstn(rstn), .vsync(vsync_b), .draw(b_if),
    .buffer_select(b_bsel), .display_select(b_dsel),
    .fb0_write_en(b_e0), .fb0_write_addr(b_a0), .fb0_write_data(b_d0),
    .fb1_write_en(b_e1), .fb1_write_addr(b_a1), .fb1_write_data(b_d1)
`ifdef FRAME_SWAP_STATS_EN
    , .frames_presented(b_fp), .vsyncs_missed(b_vm), .writes_dropped(b_wd)
`endif
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic en, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    a_if.draw_write_en   = en;
    a_if.draw_write_addr = addr;
    a_if.draw_write_data = data;
  endtask

  initial begin
    rstn = 1'b0;
    vsync_a = 1'b0; vsync_b = 1'b0;
    wr(1'b1, 15'd9, 12'h111);
    a_if.frame_done = 1'b0;
    b_if.draw_write_en = 1'b0; b_if.draw_write_addr = '0; b_if.draw_write_data = '0;
    b_if.frame_done = 1'b0;
    @(negedge clk);
    step(); step(); step();

    // Reset values, a write held during reset goes nowhere
    chk("rst_draw_start", a_if.draw_start, 0);
    chk("rst_draw_ack",   a_if.draw_ack,   0);
    chk("rst_bsel",       a_bsel, 0);
    chk("rst_dsel",       a_dsel, 1);
    chk("rst_fb0_en",     a_e0, 0);
    chk("rst_fb0_addr",   a_a0, 0);
    chk("rst_fb1_en",     a_e1, 0);

    // Release: draw_start one cycle later; the write in START is dropped
    rstn = 1'b1;
    wr(1'b1, 15'd5, 12'h555);
    step();
    chk("start_pulse",   a_if.draw_start, 1);
    chk("start_no_ack",  a_if.draw_ack, 0);
    chk("start_drop_e0", a_e0, 0);
    chk("start_drop_e1", a_e1, 0);

    // Write in DRAWING to back buffer 0
    wr(1'b1, 15'd100, 12'hABC);
    step();
    chk("start_once", a_if.draw_start, 0);
    chk("w0_en",      a_e0, 1);
    chk("w0_addr",    a_a0, 100);
    chk("w0_data",    a_d0, 12'hABC);
    chk("w0_other",   a_e1, 0);
    wr(1'b0, 15'd0, 12'h000);
    step();
    chk("w0_idle", a_e0, 0);

    // frame_done then a late vsync
    a_if.frame_done = 1'b1;
    step();
    wr(1'b1, 15'd200, 12'h123);
    step();
    chk("wait_wr_en",   a_e0, 1);
    chk("wait_wr_addr", a_a0, 200);
    wr(1'b0, 15'd0, 12'h000);
    repeat (5) step();
    chk("wait_no_ack", a_if.draw_ack, 0);
    chk("wait_bsel",   a_bsel, 0);
    vsync_a = 1'b1;
    wr(1'b1, 15'd300, 12'h0F0);
    step();
    chk("swap_ack",   a_if.draw_ack, 1);
    chk("swap_bsel",  a_bsel, 1);
    chk("swap_dsel",  a_dsel, 0);
    chk("swap_w_old", a_e0, 1);
    chk("swap_w_adr", a_a0, 300);
    chk("swap_w_e1",  a_e1, 0);

    // Write during the SWAP cycle reaches neither buffer
    vsync_a = 1'b0;
    a_if.frame_done = 1'b0;
    wr(1'b1, 15'd400, 12'h444);
    step();
    chk("swapw_e0",   a_e0, 0);
    chk("swapw_e1",   a_e1, 0);
    chk("ack_pulse1", a_if.draw_ack, 0);

    // Writes now go to buffer 1; out-of-range address forwarded as is
    wr(1'b1, 15'd500, 12'h5A5);
    step();
    chk("w1_en",   a_e1, 1);
    chk("w1_addr", a_a1, 500);
    chk("w1_data", a_d1, 12'h5A5);
    chk("w1_e0",   a_e0, 0);
    wr(1'b1, 15'h7FFF, 12'hFFF);
    step();
    chk("oob_addr", a_a1, 15'h7FFF);
    chk("oob_en",   a_e1, 1);
    wr(1'b0, 15'd0, 12'h000);

    // frame_done together with vsync in DRAWING: no swap on that vsync
    a_if.frame_done = 1'b1;
    vsync_a = 1'b1;
    step();
    chk("sim_no_ack", a_if.draw_ack, 0);
    chk("sim_bsel",   a_bsel, 1);
    vsync_a = 1'b0;
    repeat (3) step();
    chk("sim_still_no_ack", a_if.draw_ack, 0);
    vsync_a = 1'b1;
    step();
    chk("sim_ack",  a_if.draw_ack, 1);
    chk("sim_bsel2", a_bsel, 0);
    vsync_a = 1'b0;
    a_if.frame_done = 1'b0;
    step();
`ifdef FRAME_SWAP_STATS_EN
    chk("st_frames",  a_fp, 2);
    chk("st_missed",  a_vm, 1);
    chk("st_dropped", a_wd, 2);
`endif

    // Another swap so buffer_select=1, then reset in WAIT_VSYNC with a write in flight
    a_if.frame_done = 1'b1;
    step();
    vsync_a = 1'b1;
    step();
    chk("pre_rst_bsel", a_bsel, 1);
    vsync_a = 1'b0;
    a_if.frame_done = 1'b0;
    step();
    a_if.frame_done = 1'b1;
    step();
    wr(1'b1, 15'd77, 12'h777);
    rstn = 1'b0;
    step();
    chk("mrst_bsel",  a_bsel, 0);
    chk("mrst_dsel",  a_dsel, 1);
    chk("mrst_e0",    a_e0, 0);
    chk("mrst_e1",    a_e1, 0);
    chk("mrst_a1",    a_a1, 0);
    chk("mrst_ack",   a_if.draw_ack, 0);
    chk("mrst_start", a_if.draw_start, 0);
    wr(1'b0, 15'd0, 12'h000);
    a_if.frame_done = 1'b0;
    rstn = 1'b1;
    b_if.frame_done = 1'b1;
    step();
    chk("restart_pulse", a_if.draw_start, 1);
`ifdef FRAME_SWAP_STATS_EN
    chk("mrst_frames", a_fp, 0);
`endif

    // VSYNC_DIVIDE=3: vsync every 10 cycles, frame always ready
    acks = 0;
    for (int k = 1; k <= 9; k++) begin
      repeat (9) begin
        step();
        if (b_if.draw_ack) acks++;
      end
      vsync_b = 1'b1;
      step();
      vsync_b = 1'b0;
      chk($sformatf("div3_ack_v%0d", k), b_if.draw_ack, (k % 3 == 0) ? 1 : 0);
      if (b_if.draw_ack) acks++;
    end
    chk("div3_ack_total", acks, 3);
    chk("div3_bsel", b_bsel, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
